ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_pkg.sv | 74 +++++++
 rtl/ps2_key_decoder.sv | 124 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_pkg.sv
// Shared constants for the PS/2 key decoder: key bit positions, scancodes,
// FSM state encoding and the scancode-to-key lookup.
package ps2_key_pkg;

  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;
  localparam logic [2:0] KEY_P     = 3'd7;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_PAUSE  = 8'hE1;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_P      = 8'h4D;

  // Bytes following E1 in the Pause make sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK,
    SKIP
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  // Arrow codes only count when E0-prefixed; without it they are keypad keys.
  function automatic key_map_t map_code(input logic [7:0] code, input logic ext);
    key_map_t m;
    m.hit = 1'b0;
    m.idx = '0;
    if (ext) begin
      case (code)
        SC_LEFT:  begin m.hit = 1'b1; m.idx = KEY_LEFT;  end
        SC_RIGHT: begin m.hit = 1'b1; m.idx = KEY_RIGHT; end
        SC_UP:    begin m.hit = 1'b1; m.idx = KEY_UP;    end
        SC_DOWN:  begin m.hit = 1'b1; m.idx = KEY_DOWN;  end
        default:  ;
      endcase
    end else begin
      case (code)
        SC_SPACE: begin m.hit = 1'b1; m.idx = KEY_SPACE; end
        SC_ENTER: begin m.hit = 1'b1; m.idx = KEY_ENTER; end
        SC_ESC:   begin m.hit = 1'b1; m.idx = KEY_ESC;   end
        SC_P:     begin m.hit = 1'b1; m.idx = KEY_P;     end
        default:  ;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_decoder.sv
// Turns a stream of PS/2 set-2 scancode bytes into a held 8-key state vector
// with per-change event pulses and an error pulse on keyboard error bytes.
module ps2_key_decoder
  import ps2_key_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ready,
  output logic [7:0] keys,
  output logic       key_evt,
  output logic [2:0] evt_idx,
  output logic       evt_make,
  output logic       err
);

  logic       rdy_d;
  logic       consume;
  state_t     state, state_n;
  logic [2:0] skip_cnt, skip_n;
  logic [7:0] keys_n;
  logic       evt_n, make_n, err_n;
  logic [2:0] idx_n;
  logic       do_decode, dec_ext, dec_make;
  logic       is_err_byte, is_ignored;
  key_map_t   km;

  assign consume     = ready & ~rdy_d;
  assign is_err_byte = (data == SC_ERR_LO) || (data == SC_ERR_HI);
  assign is_ignored  = (data == SC_BAT) || (data == SC_ACK) ||
                       (data == SC_ECHO) || (data == SC_RESEND);
  assign km          = map_code(data, dec_ext);

  always_comb begin
    state_n   = state;
    skip_n    = skip_cnt;
    do_decode = 1'b0;
    dec_ext   = 1'b0;
    dec_make  = 1'b0;
    if (consume) begin
      if (is_err_byte) begin
        state_n = IDLE;
        skip_n  = '0;
      end else if (state == SKIP) begin
        skip_n = skip_cnt - 3'd1;
        if (skip_cnt <= 3'd1) state_n = IDLE;
      end else if (!is_ignored) begin
        case (state)
          IDLE: begin
            if (data == SC_BREAK) state_n = BRK;
            else if (data == SC_EXT) state_n = EXT;
            else if (data == SC_PAUSE) begin
              state_n = SKIP;
              skip_n  = PAUSE_SKIP;
            end else begin
              do_decode = 1'b1;
              dec_make  = 1'b1;
            end
          end
          EXT: begin
            if (data == SC_BREAK) state_n = EXT_BRK;
            else begin
              state_n   = IDLE;
              do_decode = 1'b1;
              dec_ext   = 1'b1;
              dec_make  = 1'b1;
            end
          end
          BRK: begin
            state_n   = IDLE;
            do_decode = 1'b1;
          end
          EXT_BRK: begin
            state_n   = IDLE;
            do_decode = 1'b1;
            dec_ext   = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  // Events fire only on an actual bit change so typematic repeats stay silent.
  always_comb begin
    keys_n = keys;
    evt_n  = 1'b0;
    idx_n  = evt_idx;
    make_n = evt_make;
    err_n  = 1'b0;
    if (consume && is_err_byte) begin
      keys_n = '0;
      err_n  = 1'b1;
    end else if (do_decode && km.hit && (keys[km.idx] != dec_make)) begin
      keys_n[km.idx] = dec_make;
      evt_n          = 1'b1;
      idx_n          = km.idx;
      make_n         = dec_make;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_d    <= 1'b1;
      state    <= IDLE;
      skip_cnt <= '0;
      keys     <= '0;
      key_evt  <= 1'b0;
      evt_idx  <= '0;
      evt_make <= 1'b0;
      err      <= 1'b0;
    end else begin
      rdy_d    <= ready;
      state    <= state_n;
      skip_cnt <= skip_n;
      keys     <= keys_n;
      key_evt  <= evt_n;
      evt_idx  <= idx_n;
      evt_make <= make_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed table-driven bench for ps2_key_decoder plus hand-written corner sequences.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       ready;
  logic [7:0] keys;
  logic       key_evt;
  logic [2:0] evt_idx;
  logic       evt_make;
  logic       err;

  int errors = 0;
  int checks = 0;
  int evt_seen = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  ps2_key_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .data     (data),
    .ready    (ready),
    .keys     (keys),
    .key_evt  (key_evt),
    .evt_idx  (evt_idx),
    .evt_make (evt_make),
    .err      (err)
  );

  always @(posedge clk) begin
    #1;
    if (key_evt) evt_seen++;
    if (err) err_seen++;
  end

  typedef struct {
    logic [7:0] b;
    logic [7:0] exp_keys;
    int         exp_evts;
    int         exp_errs;
    logic [2:0] exp_idx;
    logic       exp_make;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(negedge clk);
    data  = b;
    ready = 1'b1;
    repeat (hold) @(negedge clk);
    ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_checked(input string name, input logic [7:0] b, input int hold,
                              input logic [7:0] ek, input int ee);
    int e0, r0;
    e0 = evt_seen;
    r0 = err_seen;
    send_byte(b, hold);
    check({name, " keys"}, int'(keys), int'(ek));
    check({name, " evts"}, evt_seen - e0, ee);
    check({name, " errs"}, err_seen - r0, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int e0, r0;
    vecs = '{
      '{8'h29, 8'h10, 1, 0, 3'd4, 1'b1},
      '{8'hF0, 8'h10, 0, 0, 3'd4, 1'b1},
      '{8'h29, 8'h00, 1, 0, 3'd4, 1'b0},
      '{8'hE0, 8'h00, 0, 0, 3'd4, 1'b0},
      '{8'h75, 8'h04, 1, 0, 3'd2, 1'b1},
      '{8'hE0, 8'h04, 0, 0, 3'd2, 1'b1},
      '{8'hF0, 8'h04, 0, 0, 3'd2, 1'b1},
      '{8'h75, 8'h00, 1, 0, 3'd2, 1'b0},
      '{8'h75, 8'h00, 0, 0, 3'd2, 1'b0},
      '{8'h5A, 8'h20, 1, 0, 3'd5, 1'b1},
      '{8'h5A, 8'h20, 0, 0, 3'd5, 1'b1},
      '{8'h5A, 8'h20, 0, 0, 3'd5, 1'b1},
      '{8'hE0, 8'h20, 0, 0, 3'd5, 1'b1},
      '{8'h6B, 8'h21, 1, 0, 3'd0, 1'b1},
      '{8'hFF, 8'h00, 0, 1, 3'd0, 1'b1},
      '{8'h6B, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'hE1, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'h14, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'h77, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'hE1, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'hF0, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'h14, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'hF0, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'h77, 8'h00, 0, 0, 3'd0, 1'b1},
      '{8'h4D, 8'h80, 1, 0, 3'd7, 1'b1},
      '{8'hAA, 8'h80, 0, 0, 3'd7, 1'b1},
      '{8'hE0, 8'h80, 0, 0, 3'd7, 1'b1},
      '{8'hFA, 8'h80, 0, 0, 3'd7, 1'b1},
      '{8'h74, 8'h82, 1, 0, 3'd1, 1'b1},
      '{8'hF0, 8'h82, 0, 0, 3'd1, 1'b1},
      '{8'h00, 8'h00, 0, 1, 3'd1, 1'b1},
      '{8'h74, 8'h00, 0, 0, 3'd1, 1'b1},
      '{8'h76, 8'h40, 1, 0, 3'd6, 1'b1},
      '{8'hE0, 8'h40, 0, 0, 3'd6, 1'b1},
      '{8'h72, 8'h48, 1, 0, 3'd3, 1'b1},
      '{8'h12, 8'h48, 0, 0, 3'd3, 1'b1}
    };

    // Reset with ready already high: that level must not be consumed afterwards.
    rst   = 1'b0;
    data  = 8'h29;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset keys", int'(keys), 0);
    check("reset key_evt", int'(key_evt), 0);
    check("reset evt_idx", int'(evt_idx), 0);
    check("reset evt_make", int'(evt_make), 0);
    check("reset err", int'(err), 0);
    e0 = evt_seen;
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("ready high at release evts", evt_seen - e0, 0);
    check("ready high at release keys", int'(keys), 0);
    ready = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      e0 = evt_seen;
      r0 = err_seen;
      send_byte(vecs[i].b, 2);
      check($sformatf("vec%0d keys", i), int'(keys), int'(vecs[i].exp_keys));
      check($sformatf("vec%0d evts", i), evt_seen - e0, vecs[i].exp_evts);
      check($sformatf("vec%0d errs", i), err_seen - r0, vecs[i].exp_errs);
      check($sformatf("vec%0d evt_idx", i), int'(evt_idx), int'(vecs[i].exp_idx));
      check($sformatf("vec%0d evt_make", i), int'(evt_make), int'(vecs[i].exp_make));
    end

    // Release esc, then hold a single 76 for 50 cycles: one event only.
    send_checked("esc brk prefix", 8'hF0, 2, 8'h48, 0);
    send_checked("esc release", 8'h76, 2, 8'h08, 1);
    send_checked("esc long hold", 8'h76, 50, 8'h48, 1);

    // Reset after an E0 prefix discards it.
    send_checked("pre-reset E0", 8'hE0, 2, 8'h48, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset keys", int'(keys), 0);
    send_checked("6B after reset", 8'h6B, 2, 8'h00, 0);

    // Prefix persists over a long gap; also check the one-cycle latency.
    send_checked("long gap E0", 8'hE0, 2, 8'h00, 0);
    repeat (200) @(negedge clk);
    data  = 8'h6B;
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("latency key_evt", int'(key_evt), 1);
    check("latency keys", int'(keys), 8'h01);
    check("latency evt_idx", int'(evt_idx), 0);
    check("latency evt_make", int'(evt_make), 1);
    @(posedge clk);
    #1;
    check("pulse width key_evt", int'(key_evt), 0);
    @(negedge clk);
    ready = 1'b0;
    repeat (3) @(negedge clk);

    // Extended break of left, via E0 F0 with an ack byte in the middle.
    send_checked("ext brk E0", 8'hE0, 2, 8'h01, 0);
    send_checked("ext brk F0", 8'hF0, 2, 8'h01, 0);
    send_checked("ext brk FE", 8'hFE, 2, 8'h01, 0);
    send_checked("ext brk 6B", 8'h6B, 2, 8'h00, 1);
    check("ext brk evt_make", int'(evt_make), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
